test_module: RTL and testbench
==============================

TEST_MODULE -- requirements
Module: test_module

Interface
REQ-001 Parameter: WIDTH, default 4, counter width in bits (legal range 2..16).
REQ-002 Parameter: MAX_VAL, default 2**WIDTH-1, terminal count value (legal range 1..2**WIDTH-1).
REQ-003 Parameter: RST_VAL, default 0, value loaded on reset and on wrap (legal range 0..MAX_VAL).
REQ-004 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 Port: rst  input  1  asynchronous, active-low reset: asserted when 0, released when 1.
REQ-006 Port: count  output  WIDTH  current counter value, registered.
REQ-007 Port: tc  output  1  terminal-count flag, high while count == MAX_VAL.
REQ-008 Port: wrap  output  1  registered one-cycle pulse, high in the cycle after count wraps.

Function
REQ-009 Each rising clk edge with rst high: count SHALL become count+1 when count < MAX_VAL.
REQ-010 Each rising clk edge with rst high: count SHALL become RST_VAL when count == MAX_VAL (wrap-around).
REQ-011 Counter SHALL have no enable input; it advances on every clock edge while out of reset.
REQ-012 Latency: count SHALL change on the same rising edge that samples rst high; there is no extra pipeline stage.
REQ-013 First edge after release: count SHALL go from RST_VAL to RST_VAL+1.
REQ-014 tc SHALL be combinational from the count register: tc = (count == MAX_VAL).
REQ-015 wrap SHALL be 1 for exactly the one cycle following a wrap edge, and 0 otherwise.
REQ-016 Arithmetic: increment SHALL be unsigned modulo 2**WIDTH; count SHALL never exceed MAX_VAL.
REQ-017 With default parameters, count SHALL cycle 0,1,...,15,0 and wrap SHALL pulse every 16 cycles.
REQ-018 Outputs SHALL never be X or Z after the first reset assertion.

Reset
REQ-019 rst low SHALL immediately, with no clock needed, set count=RST_VAL, wrap=0, and the optional wrap_cnt=0.
REQ-020 While rst is low, all registers SHALL hold their reset values regardless of clk.
REQ-021 Reset asserted mid-count SHALL abort the sequence; counting SHALL restart from RST_VAL after release.
REQ-022 Reset release SHALL be treated as synchronous to clk by the integrator; the design SHALL add no release synchronizer.

Configuration
REQ-023 Macro TEST_MODULE_WRAPCNT_EN, when defined, SHALL add the output port wrap_cnt (input/output: output, width 8): a wrap counter incremented on each wrap edge, saturating at 255 and cleared by reset.
REQ-024 Without TEST_MODULE_WRAPCNT_EN, the wrap_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-025 Clock period 10 ns, rst=0 for 0-15 ns, then 1 -> count=0 through 15 ns; count=1 at 25 ns, 2 at 35 ns, incrementing once per edge with no skipped or missed edge.
REQ-026 Run 16+ cycles after release -> count 15 with tc=1, then 0 on the next edge with wrap=1 for one cycle.
REQ-027 Drive rst=0 at 115 ns between edges for 10 ns -> count=0 immediately without a clock edge; after release it restarts at 1 on the first edge.
REQ-028 Parameters WIDTH=4, MAX_VAL=9, RST_VAL=2 -> sequence 2..9,2; tc high only at 9.
REQ-029 With TEST_MODULE_WRAPCNT_EN: run 300 wraps -> wrap_cnt=255 (saturated); reset -> 0.
REQ-030 Check every rising clk edge while rst is high -> count changes exactly once per 10 ns period (no early or late update).

Source files
------------

// File: rtl/test_module.sv
// test_module: free-running up counter with terminal-count flag and a registered wrap pulse; count updates on the edge that samples rst high, no backpressure.
// Optional 8-bit saturating wrap counter output wrap_cnt is enabled by defining TEST_MODULE_WRAPCNT_EN.
module test_module #(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = (2**WIDTH) - 1,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
`ifdef TEST_MODULE_WRAPCNT_EN
  ,
  output logic [7:0]       wrap_cnt
`endif
);

  localparam logic [WIDTH-1:0] MAX_L = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_L = WIDTH'(RST_VAL);

  logic at_max;

  assign at_max = (count == MAX_L);
  assign tc     = at_max;

  // count never exceeds MAX_L, so the increment path cannot overflow the register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= RST_L;
      wrap  <= 1'b0;
    end else begin
      wrap  <= at_max;
      count <= at_max ? RST_L : count + 1'b1;
    end
  end

`ifdef TEST_MODULE_WRAPCNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap_cnt <= 8'd0;
    end else if (at_max && (wrap_cnt != 8'hFF)) begin
      wrap_cnt <= wrap_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_test_module.sv
// Directed bench for test_module: default instance (0..15) and a 2..9 instance share clock and reset.
module tb_test_module;

  logic       clk;
  logic       rst;
  logic [3:0] count_a;
  logic       tc_a;
  logic       wrap_a;
  logic [3:0] count_b;
  logic       tc_b;
  logic       wrap_b;
`ifdef TEST_MODULE_WRAPCNT_EN
  logic [7:0] wrap_cnt_a;
  logic [7:0] wrap_cnt_b;
`endif

  int checks = 0;
  int errors = 0;

  int exp_a  = 0;
  int exp_wa = 0;
  int exp_b  = 2;
  int exp_wb = 0;
  int exp_wc = 0;

  test_module u_dut_a (
    .clk   (clk),
    .rst   (rst),
    .count (count_a),
    .tc    (tc_a),
    .wrap  (wrap_a)
`ifdef TEST_MODULE_WRAPCNT_EN
    ,
    .wrap_cnt (wrap_cnt_a)
`endif
  );

  test_module #(
    .WIDTH   (4),
    .MAX_VAL (9),
    .RST_VAL (2)
  ) u_dut_b (
    .clk   (clk),
    .rst   (rst),
    .count (count_b),
    .tc    (tc_b),
    .wrap  (wrap_b)
`ifdef TEST_MODULE_WRAPCNT_EN
    ,
    .wrap_cnt (wrap_cnt_b)
`endif
  );

  // Rising edges at 10, 20, 30 ns...; falling edges at 5, 15, 25 ns... are the sample points.
  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge with rst high has passed since the last sample point.
  task automatic advance();
    if (exp_a == 15) begin
      exp_a  = 0;
      exp_wa = 1;
      if (exp_wc < 255) exp_wc++;
    end else begin
      exp_a++;
      exp_wa = 0;
    end
    if (exp_b == 9) begin
      exp_b  = 2;
      exp_wb = 1;
    end else begin
      exp_b++;
      exp_wb = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_count_a"}, 16'(count_a), 16'(exp_a));
    chk({tag, "_tc_a"},    16'(tc_a),    16'(exp_a == 15));
    chk({tag, "_wrap_a"},  16'(wrap_a),  16'(exp_wa));
    chk({tag, "_count_b"}, 16'(count_b), 16'(exp_b));
    chk({tag, "_tc_b"},    16'(tc_b),    16'(exp_b == 9));
    chk({tag, "_wrap_b"},  16'(wrap_b),  16'(exp_wb));
  endtask

  task automatic reset_model();
    exp_a  = 0;
    exp_wa = 0;
    exp_b  = 2;
    exp_wb = 0;
    exp_wc = 0;
  endtask

  initial begin
    rst = 1'b0;

    // Reset held across the 10 ns edge
    #12;
    chk("rst_count_a", 16'(count_a), 16'd0);
    chk("rst_tc_a",    16'(tc_a),    16'd0);
    chk("rst_wrap_a",  16'(wrap_a),  16'd0);
    chk("rst_count_b", 16'(count_b), 16'd2);
    chk("rst_tc_b",    16'(tc_b),    16'd0);
    chk("rst_wrap_b",  16'(wrap_b),  16'd0);
`ifdef TEST_MODULE_WRAPCNT_EN
    chk("rst_wrap_cnt_a", 16'(wrap_cnt_a), 16'd0);
`endif

    @(negedge clk);  // 15 ns
    chk("count_at_15", 16'(count_a), 16'd0);
    rst = 1'b1;
    reset_model();

    @(negedge clk);  // 25 ns
    advance();
    chk("count_at_25", 16'(count_a), 16'd1);
    chk("b_at_25", 16'(count_b), 16'd3);
    check_all("run1");
    @(negedge clk);  // 35 ns
    advance();
    chk("count_at_35", 16'(count_a), 16'd2);
    check_all("run1");

    repeat (8) begin
      @(negedge clk);
      advance();
      check_all("run1");
    end
    // 115 ns: ten edges taken; b went 2..9 then 2,3,4
    chk("count_at_115", 16'(count_a), 16'd10);
    chk("b_at_115", 16'(count_b), 16'd4);

    // Mid-count asynchronous reset between edges
    rst = 1'b0;
    #1;
    reset_model();
    chk("async_rst_count_a", 16'(count_a), 16'd0);
    chk("async_rst_count_b", 16'(count_b), 16'd2);
    check_all("async_rst");

    @(posedge clk);  // 120 ns edge while in reset
    #1;
    chk("hold_count_a", 16'(count_a), 16'd0);
    check_all("hold");

    @(negedge clk);  // 125 ns
    rst = 1'b1;

    @(negedge clk);  // 135 ns
    advance();
    chk("restart_count_a", 16'(count_a), 16'd1);
    chk("restart_count_b", 16'(count_b), 16'd3);
    check_all("run2");

    repeat (14) begin
      @(negedge clk);
      advance();
      check_all("run2");
    end
    // 275 ns: terminal count
    chk("tc_count_a", 16'(count_a), 16'd15);
    chk("tc_flag_a",  16'(tc_a),    16'd1);
    chk("tc_wrap_a",  16'(wrap_a),  16'd0);

    @(negedge clk);  // 285 ns: wrapped
    advance();
    chk("wrapped_count_a", 16'(count_a), 16'd0);
    chk("wrapped_tc_a",    16'(tc_a),    16'd0);
    chk("wrapped_pulse_a", 16'(wrap_a),  16'd1);
    check_all("wrap");

    @(negedge clk);  // 295 ns: pulse is one cycle wide
    advance();
    chk("post_wrap_count_a", 16'(count_a), 16'd1);
    chk("post_wrap_pulse_a", 16'(wrap_a),  16'd0);
    check_all("wrap");

    repeat (48) begin
      @(negedge clk);
      advance();
      check_all("run3");
    end

`ifdef TEST_MODULE_WRAPCNT_EN
    repeat (300 * 16) begin
      @(negedge clk);
      advance();
      if (wrap_a === 1'b1) chk("wrap_cnt_track", 16'(wrap_cnt_a), 16'(exp_wc));
    end
    chk("wrap_cnt_sat", 16'(wrap_cnt_a), 16'd255);
    check_all("long");
    rst = 1'b0;
    #1;
    reset_model();
    chk("wrap_cnt_rst", 16'(wrap_cnt_a), 16'd0);
    check_all("long_rst");
    @(negedge clk);
    rst = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
